// File: rtl/ex_result_stage_if.sv
// Bundle between the ALU/decode side, the EX result stage and MEM/fetch.
// slave: stage side (i_* in, o_* out); master: driver side (i_* out, o_* in).
interface ex_result_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5
);
   logic                  i_flush;
   logic                  i_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] i_result;
   logic                  i_zf;
   logic                  i_cf;
   logic                  i_of;
   logic                  i_sf;
   logic [RD_WIDTH-1:0]   i_rd;
   logic                  i_wb_en;
   logic                  i_is_branch;
   logic [2:0]            i_funct3;
   logic [DATA_WIDTH-1:0] i_target;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_result;
   logic [RD_WIDTH-1:0]   o_rd;
   logic                  o_wb_en;
   logic                  o_br_taken;
   logic [DATA_WIDTH-1:0] o_br_target;

   modport slave (
      input  i_flush, i_valid, i_result,
      input  i_zf, i_cf, i_of, i_sf,
      input  i_rd, i_wb_en, i_is_branch,
      input  i_funct3, i_target, i_ready,
      output o_ready, o_valid, o_result,
      output o_rd, o_wb_en, o_br_taken,
      output o_br_target
   );

   modport master (
      output i_flush, i_valid, i_result,
      output i_zf, i_cf, i_of, i_sf,
      output i_rd, i_wb_en, i_is_branch,
      output i_funct3, i_target, i_ready,
      input  o_ready, o_valid, o_result,
      input  o_rd, o_wb_en, o_br_taken,
      input  o_br_target
   );
endinterface

// File: rtl/ex_result_stage.sv
// EX->MEM stage: 2-entry skid buffer for ALU result, branch decision, rd/wb.
// Ports: i_clk, i_rst (sync, active-high), bus (ex_result_stage_if.slave).
module ex_result_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_WIDTH   = 5
) (
   input logic               i_clk,
   input logic               i_rst,
   ex_result_stage_if.slave  bus
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [RD_WIDTH-1:0]   rd;
      logic                  wb_en;
      logic                  br_taken;
      logic [DATA_WIDTH-1:0] target;
   } entry_t;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t new_entry;
   logic   main_vld_q, main_vld_d;
   logic   skid_vld_q, skid_vld_d;
   logic   br_cond;
   logic   accept;
   logic   pop;

   // Branches run through the ALU as i_a - i_b, so the
   // comparison falls out of the subtract flags.
   always_comb begin
      br_cond = 1'b0;
      case (bus.i_funct3)
         3'b000:  br_cond = bus.i_zf;
         3'b001:  br_cond = ~bus.i_zf;
         3'b100:  br_cond = bus.i_sf ^ bus.i_of;
         3'b101:  br_cond = ~(bus.i_sf ^ bus.i_of);
         3'b110:  br_cond = ~bus.i_cf;
         3'b111:  br_cond = bus.i_cf;
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      new_entry          = '0;
      new_entry.result   = bus.i_result;
      new_entry.rd       = bus.i_rd;
      new_entry.wb_en    = bus.i_wb_en & (bus.i_rd != '0);
      new_entry.br_taken = bus.i_is_branch & br_cond;
      new_entry.target   = bus.i_target;
   end

   // Ready depends only on skid occupancy, which cuts the
   // combinational path from downstream i_ready.
   assign accept = bus.i_valid & ~skid_vld_q;
   assign pop    = main_vld_q & bus.i_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (bus.i_flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         // Skid full implies main full and no accept.
         if (pop) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_vld_q || pop) begin
            main_d     = new_entry;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = new_entry;
            skid_vld_d = 1'b1;
         end
      end else if (pop) begin
         main_vld_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign bus.o_ready     = ~skid_vld_q;
   assign bus.o_valid     = main_vld_q;
   assign bus.o_result    = main_q.result;
   assign bus.o_rd        = main_q.rd;
   assign bus.o_wb_en     = main_q.wb_en;
   assign bus.o_br_taken  = main_q.br_taken;
   assign bus.o_br_target = main_q.target;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: vector table plus
// stream, backpressure, flush and reset sequences.
module tb_ex_result_stage;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   ex_result_stage_if #(.DATA_WIDTH(32), .RD_WIDTH(5)) bus ();

   ex_result_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic        zf;
      logic        cf;
      logic        of_;
      logic        sf;
      logic        br;
      logic [4:0]  rd;
      logic        wb;
      logic [31:0] res;
      logic [31:0] tgt;
      logic        exp_tk;
      logic        exp_wb;
   } vec_t;

   vec_t vec [12];

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.i_valid     = 1'b0;
      bus.i_flush     = 1'b0;
      bus.i_result    = '0;
      bus.i_zf        = 1'b0;
      bus.i_cf        = 1'b0;
      bus.i_of        = 1'b0;
      bus.i_sf        = 1'b0;
      bus.i_rd        = '0;
      bus.i_wb_en     = 1'b0;
      bus.i_is_branch = 1'b0;
      bus.i_funct3    = '0;
      bus.i_target    = '0;
   endtask

   task automatic send(input logic [31:0] r);
      bus.i_valid  = 1'b1;
      bus.i_result = r;
      bus.i_rd     = 5'd1;
      bus.i_wb_en  = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle();
      bus.i_ready = 1'b1;
      rst = 1'b1;

      //              f3    zf cf of sf br rd   wb res           tgt           tk wb
      vec[0]  = '{3'b100, 0, 0, 0, 1, 1, 5'd3, 1, 32'h11, 32'h100, 1, 1};
      vec[1]  = '{3'b100, 0, 0, 1, 1, 1, 5'd3, 1, 32'h12, 32'h104, 0, 1};
      vec[2]  = '{3'b110, 0, 1, 0, 0, 1, 5'd4, 0, 32'h13, 32'h108, 0, 0};
      vec[3]  = '{3'b010, 1, 1, 1, 1, 1, 5'd4, 0, 32'h14, 32'h10c, 0, 0};
      vec[4]  = '{3'b000, 1, 0, 0, 0, 1, 5'd2, 0, 32'h0,  32'h200, 1, 0};
      vec[5]  = '{3'b001, 1, 0, 0, 0, 1, 5'd2, 0, 32'h0,  32'h204, 0, 0};
      vec[6]  = '{3'b101, 0, 0, 0, 0, 1, 5'd2, 0, 32'h5,  32'h208, 1, 0};
      vec[7]  = '{3'b111, 0, 1, 0, 0, 1, 5'd2, 0, 32'h6,  32'h20c, 1, 0};
      vec[8]  = '{3'b000, 1, 0, 0, 0, 0, 5'd7, 1, 32'h0,  32'h210, 0, 1};
      vec[9]  = '{3'b000, 0, 0, 0, 0, 0, 5'd0, 1, 32'h99, 32'h0,   0, 0};
      vec[10] = '{3'b000, 0, 0, 0, 0, 0, 5'd5, 1, 32'h98, 32'h0,   0, 1};
      vec[11] = '{3'b011, 1, 0, 1, 0, 1, 5'd9, 1, 32'hff, 32'h300, 0, 1};

      // Reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_valid", 64'(bus.o_valid), 64'd0);
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      check("rst_result", 64'(bus.o_result), 64'd0);
      check("rst_taken", 64'(bus.o_br_taken), 64'd0);
      check("rst_wb", 64'(bus.o_wb_en), 64'd0);

      // Single-entry vectors
      for (int i = 0; i < 12; i++) begin
         bus.i_valid     = 1'b1;
         bus.i_funct3    = vec[i].f3;
         bus.i_zf        = vec[i].zf;
         bus.i_cf        = vec[i].cf;
         bus.i_of        = vec[i].of_;
         bus.i_sf        = vec[i].sf;
         bus.i_is_branch = vec[i].br;
         bus.i_rd        = vec[i].rd;
         bus.i_wb_en     = vec[i].wb;
         bus.i_result    = vec[i].res;
         bus.i_target    = vec[i].tgt;
         @(negedge clk);
         idle();
         check($sformatf("v%0d_valid", i), 64'(bus.o_valid), 64'd1);
         check($sformatf("v%0d_res", i), 64'(bus.o_result), 64'(vec[i].res));
         check($sformatf("v%0d_tgt", i), 64'(bus.o_br_target), 64'(vec[i].tgt));
         check($sformatf("v%0d_rd", i), 64'(bus.o_rd), 64'(vec[i].rd));
         check($sformatf("v%0d_taken", i), 64'(bus.o_br_taken), 64'(vec[i].exp_tk));
         check($sformatf("v%0d_wb", i), 64'(bus.o_wb_en), 64'(vec[i].exp_wb));
         @(negedge clk);
         check($sformatf("v%0d_drain", i), 64'(bus.o_valid), 64'd0);
      end

      // Stream 1,2,3 with i_ready high
      for (int k = 1; k <= 3; k++) begin
         send(32'(k));
         @(negedge clk);
         check($sformatf("stream%0d_valid", k), 64'(bus.o_valid), 64'd1);
         check($sformatf("stream%0d_res", k), 64'(bus.o_result), 64'(k));
         check($sformatf("stream%0d_ready", k), 64'(bus.o_ready), 64'd1);
      end
      idle();
      @(negedge clk);
      check("stream_drain", 64'(bus.o_valid), 64'd0);

      // Backpressure A, B
      bus.i_ready = 1'b0;
      send(32'hAAAA0000);
      @(negedge clk);
      check("bp_a_ready", 64'(bus.o_ready), 64'd1);
      check("bp_a_res", 64'(bus.o_result), 64'hAAAA0000);
      send(32'h0000BBBB);
      @(negedge clk);
      check("bp_b_ready", 64'(bus.o_ready), 64'd0);
      check("bp_b_hold", 64'(bus.o_result), 64'hAAAA0000);
      send(32'h0000CCCC);
      @(negedge clk);
      check("bp_full_ready", 64'(bus.o_ready), 64'd0);
      check("bp_full_hold", 64'(bus.o_result), 64'hAAAA0000);
      idle();
      bus.i_ready = 1'b1;
      @(negedge clk);
      check("bp_pop_valid", 64'(bus.o_valid), 64'd1);
      check("bp_pop_res", 64'(bus.o_result), 64'h0000BBBB);
      check("bp_pop_ready", 64'(bus.o_ready), 64'd1);
      @(negedge clk);
      check("bp_empty", 64'(bus.o_valid), 64'd0);

      // Flush with both entries full and i_valid high
      bus.i_ready = 1'b0;
      send(32'h1);
      @(negedge clk);
      send(32'h2);
      @(negedge clk);
      check("fl_full_ready", 64'(bus.o_ready), 64'd0);
      send(32'h3);
      bus.i_flush = 1'b1;
      @(negedge clk);
      idle();
      check("fl_valid", 64'(bus.o_valid), 64'd0);
      check("fl_ready", 64'(bus.o_ready), 64'd1);

      // Flush discards a same-cycle accept into empty main
      send(32'h44);
      bus.i_flush = 1'b1;
      @(negedge clk);
      idle();
      check("fl_acc_valid", 64'(bus.o_valid), 64'd0);
      bus.i_ready = 1'b1;
      @(negedge clk);
      check("fl_acc_after", 64'(bus.o_valid), 64'd0);

      // Reset mid-transfer
      bus.i_ready = 1'b0;
      send(32'h55);
      @(negedge clk);
      send(32'h66);
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_valid", 64'(bus.o_valid), 64'd0);
      check("mrst_ready", 64'(bus.o_ready), 64'd1);
      check("mrst_res", 64'(bus.o_result), 64'd0);
      bus.i_ready = 1'b1;
      @(negedge clk);
      check("mrst_after", 64'(bus.o_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
